// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg: shared UART types and constants for the TX and RX blocks.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int CLK_FREQ_DFLT  = 1000000;
  localparam int BAUD_RATE_DFLT = 100000;
  localparam int DATA_BITS      = 8;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Parity bit that makes the total count of ones even (or odd).
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic mode);
    return (mode == PARITY_EVEN) ? ^data : ~^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_baud_cnt: 0..DIV-1 bit-time counter, held at 0 when disabled,   |
// | with a one-cycle wrap strobe.                   Rev 1.0              |
// +----------------------------------------------------------------------+
module uart_baud_cnt #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic wrap
);

  localparam int             CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en || r_cnt == CNT_MAX) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign wrap = en && (r_cnt == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx: 8N1 UART transmitter with valid/ready byte input.           |
// | Optional parity bit when UART_TX_PARITY_EN is defined.   Rev 1.0     |
// +----------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = CLK_FREQ_DFLT,
  parameter int BAUD_RATE = BAUD_RATE_DFLT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_txd,
  output logic                 tx_busy,
  output logic                 tx_done
`ifdef UART_TX_PARITY_EN
  ,
  input  logic                 parity_mode
`endif
);

  localparam int               DIV      = CLK_FREQ / BAUD_RATE;
  localparam int               BIT_W    = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  uart_state_e          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic                 w_wrap;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  assign tx_ready = (r_state == IDLE);
  assign tx_busy  = (r_state != IDLE);

  uart_baud_cnt #(
    .DIV (DIV)
  ) u_baud_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tx_busy),
    .wrap  (w_wrap)
  );

  // uart_txd is loaded one bit ahead so the pin only moves on bit boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      uart_txd  <= 1'b1;
      tx_done   <= 1'b0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (tx_valid) begin
            r_shift   <= tx_data;
            r_bit_cnt <= '0;
            uart_txd  <= 1'b0;
            r_state   <= START;
`ifdef UART_TX_PARITY_EN
            r_parity  <= parity_bit(tx_data, parity_mode);
`endif
          end
        end
        START: begin
          if (w_wrap) begin
            uart_txd <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_state  <= DATA;
          end
        end
        DATA: begin
          if (w_wrap) begin
            if (r_bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              uart_txd <= r_parity;
              r_state  <= PARITY;
`else
              uart_txd <= 1'b1;
              r_state  <= STOP;
`endif
            end else begin
              uart_txd  <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_wrap) begin
            uart_txd <= 1'b1;
            r_state  <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_wrap) begin
            r_state <= IDLE;
            tx_done <= 1'b1;
          end
        end
        default: begin
          uart_txd <= 1'b1;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx: randomized self-checking bench for uart_tx with a frame  |
// | model and a mid-bit sampling receiver.                  Rev 1.0      |
// +----------------------------------------------------------------------+
module tb_uart_tx;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD_RATE = 100000;
  localparam int DIV       = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
`ifdef UART_TX_PARITY_EN
  logic       pm       = 1'b0;
`endif
  logic       tx_ready, uart_txd, tx_busy, tx_done;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .uart_txd (uart_txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
`ifdef UART_TX_PARITY_EN
    ,
    .parity_mode (pm)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: a frame is a list of line levels, each held DIV clocks.
  logic       m_bits [NBITS];
  int         m_t      = 0;
  bit         m_active = 1'b0;
  bit         m_done   = 1'b0;
  int         cyc      = 0;
  logic [8:0] exp_q[$];
  int         rst_events = 0;
  int         n_done = 0;
  int         n_rx = 0;
  int         n_issued = 0;
  int         last_start = 0;
  int         prev_start = 0;

  function automatic logic cur_mode();
`ifdef UART_TX_PARITY_EN
    return pm;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void load_frame(input logic [7:0] d);
    int ones = 0;
    m_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_bits[i+1] = d[i];
      ones += int'(d[i]);
    end
`ifdef UART_TX_PARITY_EN
    m_bits[9] = (pm == 1'b0) ? (ones % 2 == 1) : (ones % 2 == 0);
`endif
    m_bits[NBITS-1] = 1'b1;
  endfunction

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0;
        m_done   = 1'b0;
        m_t      = 0;
        exp_q.delete();
      end else begin
        cyc++;
        m_done = 1'b0;
        if (m_active) begin
          m_t++;
          if (m_t == FRAME) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end
        end else if (tx_valid) begin
          load_frame(tx_data);
          m_active = 1'b1;
          m_t      = 0;
          exp_q.push_back({cur_mode(), tx_data});
        end
      end
    end
  end

  initial forever begin
    @(negedge rst_n);
    rst_events++;
  end

  // Every cycle, the pin and flags must match the model exactly.
  initial begin : cycle_check
    forever begin
      @(negedge clk);
      check("txd",   uart_txd, m_active ? m_bits[m_t / DIV] : 1'b1);
      check("busy",  tx_busy,  m_active);
      check("ready", tx_ready, !m_active);
      check("done",  tx_done,  m_done);
      if (tx_done === 1'b1) n_done++;
    end
  end

  // Independent receiver: detect start, sample mid-bit, compare with sent bytes.
  initial begin : rx
    forever begin
      @(negedge clk);
      if (rst_n && uart_txd === 1'b0) begin : frame_blk
        int         ev;
        logic [7:0] b;
        logic       st, sp, pb;
        logic [8:0] e;
        ev         = rst_events;
        prev_start = last_start;
        last_start = cyc;
        pb         = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        st = uart_txd;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_txd;
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        pb = uart_txd;
`endif
        repeat (DIV) @(negedge clk);
        sp = uart_txd;
        if (ev == rst_events) begin
          check("rx_start", st, 1'b0);
          check("rx_stop",  sp, 1'b1);
          check("rx_queue_nonempty", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rx_data", b, e[7:0]);
`ifdef UART_TX_PARITY_EN
            check("rx_parity", ^{b, pb}, e[8]);
`else
            check("rx_no_parity", pb | e[8], 1'b0);
`endif
            n_rx++;
          end
        end
      end
    end
  end

  task automatic accept_wait();
    int k = 0;
    while (tx_ready !== 1'b1 && k < 4 * FRAME) begin
      @(negedge clk);
      k++;
    end
    check("accept_timeout", k < 4 * FRAME, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    n_issued++;
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    accept_wait();
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((m_active || tx_busy) && k < 5 * FRAME) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", k < 5 * FRAME, 1'b1);
    repeat (DIV) @(negedge clk);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int lat;
    int done_snap;
    repeat (3) @(negedge clk);
    check("rst_txd",   uart_txd, 1'b1);
    check("rst_busy",  tx_busy,  1'b0);
    check("rst_done",  tx_done,  1'b0);
    check("rst_ready", tx_ready, 1'b1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame and tx_done latency
    send(8'hA5);
    lat = 1;
    while (tx_done !== 1'b1 && lat < 3 * FRAME) begin
      @(negedge clk);
      lat++;
    end
    check("a5_done_lat", lat, FRAME + 1);
    wait_idle();

    // Back-to-back with tx_valid held through the first frame
    send(8'h00);
    send(8'hFF);
    wait_idle();
    check("b2b_start_gap", last_start - prev_start, FRAME + 1);

    // Data changes while busy must not disturb the frame in flight
    send(8'h3C);
    repeat (30) @(negedge clk);
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    repeat (20) @(negedge clk);
    tx_data = 8'h69;
    accept_wait();
    wait_idle();

`ifdef UART_TX_PARITY_EN
    pm = 1'b0;
    send(8'h07);
    pm = 1'b1;
    send(8'h07);
    wait_idle();
    pm = 1'b0;
`endif

    // Reset in the middle of a frame, while the line is low
    send(8'hF0);
    repeat (44) @(negedge clk);
    done_snap = n_done;
    check("pre_abort_txd", uart_txd, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_txd",  uart_txd, 1'b1);
    check("abort_busy", tx_busy,  1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME + 20) @(negedge clk);
    check("abort_no_done", n_done - done_snap, 0);
    send(8'h81);
    wait_idle();

    // Randomized bytes, gaps and parity modes
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 15)) @(negedge clk);
`ifdef UART_TX_PARITY_EN
      pm = 1'($urandom_range(0, 1));
`endif
      send(8'($urandom));
    end
    wait_idle();

    // Full byte sweep, back-to-back
    for (int v = 0; v < 256; v++) begin
      send(v[7:0]);
    end
    wait_idle();

    check("frames_received", n_rx,   n_issued - 1);
    check("done_pulses",     n_done, n_issued - 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
